// File: rtl/arbitro_registrador_if.sv
// Requester/register-side bundle for arbitro_registrador: requests, data, clear and the
// register control pins, plus grant/ack handshake back to the requesters.
interface arbitro_registrador_if #(
  parameter int unsigned N = 4,
  parameter int unsigned P = 4
);
  logic [P-1:0]   req;
  logic [P*N-1:0] dado;
  logic           limpa;
  logic           reg_clear;
  logic           reg_enable;
  logic [N-1:0]   reg_D;
  logic [P-1:0]   gnt;
  logic [P-1:0]   ack;
  logic           ocupado;

  // Requesters plus the shared register.
  modport master (
    output req, dado, limpa,
    input  reg_clear, reg_enable, reg_D, gnt, ack, ocupado
  );

  // Arbiter side.
  modport slave (
    input  req, dado, limpa,
    output reg_clear, reg_enable, reg_D, gnt, ack, ocupado
  );
endinterface

// File: rtl/arbitro_registrador.sv
// Round-robin arbiter sequencing P requesters onto one shared N-bit register.
// Each write is CONCEDE -> ESCREVE -> CONFIRMA; a clear request takes priority in OCIOSO.
module arbitro_registrador #(
  parameter int unsigned N = 4,
  parameter int unsigned P = 4
) (
  input logic                  i_clock,
  input logic                  i_reset_n,
  arbitro_registrador_if.slave bus
);

  localparam int unsigned IdxW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {
    StOcioso,
    StLimpa,
    StConcede,
    StEscreve,
    StConfirma
  } state_e;

  state_e          r_state, w_state_d;
  logic [IdxW-1:0] r_ptr, w_ptr_d;
  logic [IdxW-1:0] r_dono, w_dono_d;
  logic [IdxW-1:0] w_winner;
  logic            w_found;
  logic [P-1:0]    w_onehot;

  // Explicit modulo-P wrap so non-power-of-two P never relies on counter overflow.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= P) s = s - P;
    return IdxW'(s);
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int unsigned k = 0; k < P; k++) begin
      if (!w_found && bus.req[wrap_add(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_onehot = {{(P-1){1'b0}}, 1'b1} << r_dono;

  always_comb begin
    w_state_d      = r_state;
    w_ptr_d        = r_ptr;
    w_dono_d       = r_dono;
    bus.gnt        = '0;
    bus.ack        = '0;
    bus.reg_enable = 1'b0;
    bus.reg_D      = '0;
    unique case (r_state)
      StOcioso: begin
        if (bus.limpa) begin
          w_state_d = StLimpa;
        end else if (w_found) begin
          w_state_d = StConcede;
          w_dono_d  = w_winner;
          w_ptr_d   = wrap_add(w_winner, 1);
        end
      end
      StLimpa: begin
        w_state_d = StOcioso;
      end
      StConcede: begin
        bus.gnt   = w_onehot;
        w_state_d = StEscreve;
      end
      StEscreve: begin
        bus.gnt        = w_onehot;
        bus.reg_enable = 1'b1;
        // Data passes straight through; the owner holds it stable for this cycle.
        bus.reg_D      = bus.dado[32'(r_dono) * N +: N];
        w_state_d      = StConfirma;
      end
      StConfirma: begin
        bus.gnt   = w_onehot;
        bus.ack   = w_onehot;
        w_state_d = StOcioso;
      end
      default: begin
        w_state_d = StOcioso;
      end
    endcase
  end

  // Reset also holds the shared register cleared.
  assign bus.reg_clear = ~i_reset_n | (r_state == StLimpa);
  assign bus.ocupado   = (r_state != StOcioso);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StOcioso;
      r_ptr   <= '0;
      r_dono  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_dono  <= w_dono_d;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    $onehot0(bus.gnt));
  a_ack_onehot0 : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    $onehot0(bus.ack));
  a_en_clr_excl : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    !(bus.reg_enable && bus.reg_clear));
  a_idle_quiet  : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    (r_state inside {StOcioso, StLimpa}) |-> (bus.gnt == '0 && bus.ack == '0
                                             && !bus.reg_enable));
`endif

endmodule
